// File: rtl/gray_counter.sv
// gray_counter: up/down binary counter with a registered Gray-code view.
// The count is held in binary. gray_q is registered from the same next-state
// value as bin_q, so it is always the Gray encoding of bin_q.
// Supports synchronous load of binary or Gray-coded values, wrap or
// saturate behaviour at the limits, and a terminal-count flag.
module gray_counter #(
  parameter int WIDTH = 3,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Binary to Gray: each bit is XORed with the bit above it.
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR running from the MSB down.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = ZERO_C;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] bin_r;
  logic [WIDTH-1:0] gray_r;
  logic             tc_r;
  logic [WIDTH-1:0] next_bin_s;
  logic             next_tc_s;

  // Next-state selection: load has priority over counting, counting over hold.
  always_comb begin
    next_bin_s = bin_r;
    next_tc_s  = 1'b0;
    if (load) begin
      if (load_is_gray) begin
        next_bin_s = gray2bin(load_val);
      end else begin
        next_bin_s = load_val;
      end
    end else if (en) begin
      if (up) begin
        if (bin_r == MAX_C) begin
          // At the top limit: wrap to zero or stay put; either way flag it.
          next_tc_s = 1'b1;
          if (WRAP) begin
            next_bin_s = ZERO_C;
          end else begin
            next_bin_s = bin_r;
          end
        end else begin
          next_bin_s = bin_r + ONE_C;
        end
      end else begin
        if (bin_r == ZERO_C) begin
          // At the bottom limit: wrap to all-ones or stay put; flag it.
          next_tc_s = 1'b1;
          if (WRAP) begin
            next_bin_s = MAX_C;
          end else begin
            next_bin_s = bin_r;
          end
        end else begin
          next_bin_s = bin_r - ONE_C;
        end
      end
    end else begin
      next_bin_s = bin_r;
      next_tc_s  = 1'b0;
    end
  end

  // State and output registers; Gray view derived from the next binary value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r  <= ZERO_C;
      gray_r <= ZERO_C;
      tc_r   <= 1'b0;
    end else begin
      bin_r  <= next_bin_s;
      gray_r <= bin2gray(next_bin_s);
      tc_r   <= next_tc_s;
    end
  end

  assign bin_q  = bin_r;
  assign gray_q = gray_r;
  assign tc     = tc_r;

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed-vector bench for gray_counter (WIDTH=3).
// Two instances share stimulus: one wrapping, one saturating.
module tb_gray_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic       load_is_gray;
  logic [2:0] load_val;
  logic [2:0] w_bin, w_gray, s_bin, s_gray;
  logic       w_tc, s_tc;

  int checks = 0;
  int errors = 0;

  gray_counter #(.WIDTH(3), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val),
    .bin_q(w_bin), .gray_q(w_gray), .tc(w_tc)
  );

  gray_counter #(.WIDTH(3), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val),
    .bin_q(s_bin), .gray_q(s_gray), .tc(s_tc)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Gray invariant on both instances, sampled on the falling edge.
  always @(negedge clk) begin
    check_eq("wrap_gray_inv", {29'd0, w_gray}, {29'd0, w_bin ^ (w_bin >> 1)});
    check_eq("sat_gray_inv",  {29'd0, s_gray}, {29'd0, s_bin ^ (s_bin >> 1)});
  end

  logic [2:0] gray_seq [8];
  logic       tc_seq   [8];

  initial begin
    gray_seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    tc_seq   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0;
    load_is_gray = 1'b0; load_val = 3'd0;
    #3;
    check_eq("rst_bin",  {29'd0, w_bin},  32'd0);
    check_eq("rst_gray", {29'd0, w_gray}, 32'd0);
    check_eq("rst_tc",   {31'd0, w_tc},   32'd0);
    #4 rst_n = 1'b1;
    step();

    // 1: count up through the full cycle including the wrap.
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("up_gray", {29'd0, w_gray}, {29'd0, gray_seq[i]});
      check_eq("up_tc",   {31'd0, w_tc},   {31'd0, tc_seq[i]});
    end
    check_eq("sat_top_hold", {29'd0, s_bin}, 32'd7);
    check_eq("sat_top_tc",   {31'd0, s_tc},  32'd1);

    // 2: down-wrap from 0.
    up = 1'b0;
    step();
    check_eq("dn_wrap_bin",  {29'd0, w_bin},  32'd7);
    check_eq("dn_wrap_gray", {29'd0, w_gray}, 32'd4);
    check_eq("dn_wrap_tc",   {31'd0, w_tc},   32'd1);
    step();
    check_eq("dn_bin", {29'd0, w_bin}, 32'd6);
    check_eq("dn_tc",  {31'd0, w_tc},  32'd0);

    // 3: Gray load then binary load.
    en = 1'b0; load = 1'b1; load_is_gray = 1'b1; load_val = 3'b110;
    step();
    check_eq("ldg_bin",  {29'd0, w_bin},  32'd4);
    check_eq("ldg_gray", {29'd0, w_gray}, 32'd6);
    check_eq("ldg_tc",   {31'd0, w_tc},   32'd0);
    load_is_gray = 1'b0; load_val = 3'b101;
    step();
    check_eq("ldb_bin",  {29'd0, w_bin},  32'd5);
    check_eq("ldb_gray", {29'd0, w_gray}, 32'd7);

    // 4: load wins over en.
    en = 1'b1; up = 1'b1; load_val = 3'b010;
    step();
    check_eq("ld_prio_bin", {29'd0, w_bin}, 32'd2);

    // 5: saturating instance blocked at the top.
    en = 1'b0; load_val = 3'd7;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("sat_hold_bin", {29'd0, s_bin}, 32'd7);
      check_eq("sat_hold_tc",  {31'd0, s_tc},  32'd1);
    end
    check_eq("wrap_after3_bin", {29'd0, w_bin}, 32'd2);
    up = 1'b0;
    step();
    check_eq("sat_away_bin", {29'd0, s_bin}, 32'd6);
    check_eq("sat_away_tc",  {31'd0, s_tc},  32'd0);
    en = 1'b0;
    step();
    check_eq("hold_bin",  {29'd0, s_bin},  32'd6);
    check_eq("hold_gray", {29'd0, s_gray}, 32'd5);
    check_eq("hold_tc",   {31'd0, s_tc},   32'd0);

    // 6: async reset mid-count at bin_q=5.
    load = 1'b1; load_val = 3'd4;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    check_eq("pre_rst_bin", {29'd0, w_bin}, 32'd5);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_bin",  {29'd0, w_bin},  32'd0);
    check_eq("async_rst_gray", {29'd0, w_gray}, 32'd0);
    check_eq("async_rst_tc",   {31'd0, w_tc},   32'd0);
    #1 rst_n = 1'b1;
    step();
    check_eq("resume1_bin", {29'd0, w_bin}, 32'd1);
    step();
    check_eq("resume2_bin",  {29'd0, w_bin},  32'd2);
    check_eq("resume2_gray", {29'd0, w_gray}, 32'd3);

    en = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
